// File: rtl/udiv9_seq_pkg.sv
// udiv9_seq_pkg: shared constants for the sequential restoring divider.
//   - add2 operand/result widths (the divisor/dividend defaults derive from them)
//   - FSM state encoding and the typed state enum built on it
package udiv9_seq_pkg;

    // Width of the two-operand adder used by the compare-subtract step.
    localparam int unsigned ADD2_OP_W  = 8;
    localparam int unsigned ADD2_RES_W = ADD2_OP_W + 1;

    // Default datapath widths: dividend/quotient match the adder result,
    // divisor/remainder match the adder operand.
    localparam int unsigned DIVIDEND_W_DEF = ADD2_RES_W;
    localparam int unsigned DIVISOR_W_DEF  = ADD2_OP_W;

    // FSM state encoding.
    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_RUN_ENC  = 2'd1;
    localparam logic [1:0] ST_DONE_ENC = 2'd2;

    typedef enum logic [1:0] {
        StIdle = ST_IDLE_ENC,
        StRun  = ST_RUN_ENC,
        StDone = ST_DONE_ENC
    } state_e;

endpackage

// File: rtl/udiv_step.sv
// udiv_step: one combinational restoring-division step.
//   pr_i      - shifted partial remainder (DIVISOR_W+1 bits)
//   divisor_i - divisor
//   rem_o     - next partial remainder (always < divisor_i when divisor_i != 0)
//   q_bit_o   - quotient bit: 1 when pr_i >= divisor_i
module udiv_step #(
    parameter int unsigned DIVISOR_W = 8
) (
    input  logic [DIVISOR_W:0]   pr_i,
    input  logic [DIVISOR_W-1:0] divisor_i,
    output logic [DIVISOR_W-1:0] rem_o,
    output logic                 q_bit_o
);

    logic               borrow;
    logic [DIVISOR_W:0] diff;
    logic               unused_diff_msb;

    // The borrow out of the subtraction doubles as the compare result.
    always_comb begin
        {borrow, diff} = {1'b0, pr_i} - {2'b00, divisor_i};
        q_bit_o        = ~borrow;
        // On a successful subtract the difference is < divisor, so its MSB is 0.
        rem_o          = q_bit_o ? diff[DIVISOR_W-1:0] : pr_i[DIVISOR_W-1:0];
    end

    assign unused_diff_msb = diff[DIVISOR_W];

endmodule

// File: rtl/udiv9_seq.sv
// udiv9_seq: sequential restoring unsigned divider, one quotient bit per cycle.
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid / in_ready  - request handshake; in_ready high only in IDLE
//   dividend, divisor    - operands, captured on the accepting edge
//   out_valid / out_ready- result handshake; out_valid high only in DONE
//   quotient, remainder  - registered results, held while out_valid && !out_ready
//   div_by_zero          - registered flag, valid with out_valid
// Divide by zero skips RUN: quotient = all ones, remainder = low dividend bits.
module udiv9_seq
    import udiv9_seq_pkg::*;
#(
    parameter int unsigned DIVIDEND_W = DIVIDEND_W_DEF,
    parameter int unsigned DIVISOR_W  = DIVISOR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int unsigned     CntW    = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(DIVIDEND_W - 1);

    state_e state_q, state_d;

    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
    logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
    logic [DIVISOR_W-1:0]  rem_q, rem_d;
    logic [DIVIDEND_W-1:0] quo_q, quo_d;
    logic                  dbz_q, dbz_d;

    logic                  dvs_zero;
    logic [DIVISOR_W-1:0]  step_rem;
    logic                  step_q;

    assign dvs_zero = (divisor == '0);

    // Next dividend bit (MSB of the shifting dividend) enters the partial remainder.
    udiv_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .pr_i      ({rem_q, dvd_q[DIVIDEND_W-1]}),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_q)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (in_valid) state_d = dvs_zero ? StDone : StRun;
            StRun:  if (cnt_q == '0) state_d = StDone;
            StDone: if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs, purely from state.
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
    end

    // Datapath next state.
    always_comb begin
        cnt_d = cnt_q;
        dvd_d = dvd_q;
        dvs_d = dvs_q;
        rem_d = rem_q;
        quo_d = quo_q;
        dbz_d = dbz_q;
        if (state_q == StIdle && in_valid) begin
            dvd_d = dividend;
            dvs_d = divisor;
            dbz_d = dvs_zero;
            cnt_d = dvs_zero ? '0 : CntLoad;
            rem_d = dvs_zero ? dividend[DIVISOR_W-1:0] : '0;
            quo_d = dvs_zero ? '1 : '0;
        end else if (state_q == StRun) begin
            rem_d = step_rem;
            quo_d = {quo_q[DIVIDEND_W-2:0], step_q};
            dvd_d = dvd_q << 1;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            dvd_q <= '0;
            dvs_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            dbz_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            dvd_q <= dvd_d;
            dvs_q <= dvs_d;
            rem_q <= rem_d;
            quo_q <= quo_d;
            dbz_q <= dbz_d;
        end
    end

    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_udiv9_seq.sv
// tb_udiv9_seq: directed and random checks of udiv9_seq with a result scoreboard.
module tb_udiv9_seq;

    localparam int DW     = 9;
    localparam int VW     = 8;
    localparam int NSweep = 3000;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] dividend  = '0;
    logic [VW-1:0] divisor   = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;

    typedef struct packed {
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          dbz;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    udiv9_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [DW-1:0] a, input logic [VW-1:0] b);
        exp_t          e;
        logic [DW-1:0] bx;
        logic [DW-1:0] rx;
        bx = {1'b0, b};
        if (b == '0) begin
            e.q   = '1;
            e.r   = a[VW-1:0];
            e.dbz = 1'b1;
        end else begin
            rx    = a % bx;
            e.q   = a / bx;
            e.r   = rx[VW-1:0];
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [DW-1:0] a, input logic [VW-1:0] b);
        int w;
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) chk("accept_timeout", 32'(w), 32'd0);
        @(posedge clk);
        sb.push_back(model(a, b));
        @(negedge clk);
        in_valid = 1'b0;
        // Scramble operands: they must not be sampled after acceptance.
        dividend = DW'($urandom);
        divisor  = VW'($urandom);
        chk("accepted_in_ready", 32'(in_ready), 32'd0);
    endtask

    task automatic run_one(input logic [DW-1:0] a, input logic [VW-1:0] b,
                           input int hold, input logic poke);
        int   lat;
        exp_t e;
        exp_t snap;
        out_ready = 1'b0;
        send(a, b);
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), (b == '0) ? 32'd1 : 32'(DW + 1));
        snap = {quotient, remainder, div_by_zero};
        for (int i = 0; i < hold; i++) begin
            in_valid = poke;
            @(negedge clk);
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_stable", 32'({quotient, remainder, div_by_zero}), 32'(snap));
        end
        out_ready = 1'b1;
        chk("sb_size", 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("quotient", 32'(quotient), 32'(e.q));
            chk("remainder", 32'(remainder), 32'(e.r));
            chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("drained_out_valid", 32'(out_valid), 32'd0);
        chk("drained_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_quotient", 32'(quotient), 32'd0);
        chk("rst_remainder", 32'(remainder), 32'd0);
        chk("rst_div_by_zero", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;

        // Directed cases.
        run_one(9'd300, 8'd7, 0, 1'b0);
        run_one(9'd511, 8'd1, 0, 1'b0);
        run_one(9'd3, 8'd200, 0, 1'b0);
        run_one(9'd5, 8'd0, 0, 1'b0);

        // Back-pressure in DONE with a competing request held on in_valid.
        run_one(9'd300, 8'd7, 5, 1'b1);

        // Reset in the middle of RUN, then a fresh request.
        out_ready = 1'b0;
        send(9'd300, 8'd7);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        if (sb.size() > 0) void'(sb.pop_front());
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_quotient", 32'(quotient), 32'd0);
        chk("abort_remainder", 32'(remainder), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_one(9'd100, 8'd10, 0, 1'b0);

        // Random sweep with random back-pressure; occasional zero divisor.
        for (int i = 0; i < NSweep; i++) begin
            logic [DW-1:0] a;
            logic [VW-1:0] b;
            a = DW'($urandom);
            b = ($urandom_range(0, 31) == 0) ? '0 : VW'($urandom);
            run_one(a, b, int'($urandom_range(0, 3)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
